// File: rtl/fft64_input_framer.sv
// Serial-to-parallel framer feeding fft64pt_stage1: collects N complex samples per frame
// into ping-pong banks (optionally bit-reversed) and presents a whole frame as flat buses.
module fft64_input_framer #(
  parameter int N      = 64,
  parameter int W      = 2,
  parameter int BITREV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [N*W-1:0]      frame_re,
  output logic [N*W-1:0]      frame_im,
  output logic                sync_err
);

  localparam int LOGN = $clog2(N);
  typedef logic [LOGN-1:0] idx_t;
  localparam idx_t LAST = idx_t'(N - 1);

  function automatic idx_t slot_of(input idx_t k);
    idx_t r;
    r = k;
    if (BITREV != 0) begin
      for (int b = 0; b < LOGN; b++) begin
        r[b] = k[LOGN-1-b];
      end
    end
    return r;
  endfunction

  logic signed [W-1:0] mem_re [2][N];
  logic signed [W-1:0] mem_im [2][N];

  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
  idx_t       wr_idx;

  logic       accept;
  logic       resync;
  logic       complete;
  logic       take;
  idx_t       widx_eff;
  logic [1:0] full_nxt;
  logic       wr_bank_nxt;

  assign frame_valid = full[rd_bank];

  // Completion and release always target different banks: the write bank is never FULL
  // while accepting, and only a FULL bank can be released.
  always_comb begin
    accept      = in_valid && in_ready;
    resync      = accept && in_sof && (wr_idx != '0);
    widx_eff    = resync ? '0 : wr_idx;
    complete    = accept && (widx_eff == LAST);
    take        = frame_valid && frame_ready;
    wr_bank_nxt = wr_bank ^ complete;
    full_nxt    = full;
    if (complete) full_nxt[wr_bank] = 1'b1;
    if (take)     full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_idx   <= '0;
      in_ready <= 1'b1;
      sync_err <= 1'b0;
    end else begin
      full     <= full_nxt;
      wr_bank  <= wr_bank_nxt;
      rd_bank  <= rd_bank ^ take;
      if (accept) wr_idx <= widx_eff + idx_t'(1);
      if (resync) sync_err <= 1'b1;
      in_ready <= !full_nxt[wr_bank_nxt];
    end
  end

  // Sample storage carries no reset; outputs are masked by frame_valid instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[wr_bank][slot_of(widx_eff)] <= in_re;
      mem_im[wr_bank][slot_of(widx_eff)] <= in_im;
    end
  end

  always_comb begin
    frame_re = '0;
    frame_im = '0;
    if (frame_valid) begin
      for (int s = 0; s < N; s++) begin
        frame_re[s*W +: W] = mem_re[rd_bank][idx_t'(s)];
        frame_im[s*W +: W] = mem_im[rd_bank][idx_t'(s)];
      end
    end
  end

endmodule

// File: tb/tb_fft64_input_framer.sv
// Bench for fft64_input_framer: random sample streams checked against a frame-queue model,
// with a BITREV=1 and a BITREV=0 instance sharing the same input stream.
module tb_fft64_input_framer;

  localparam int N    = 64;
  localparam int W    = 2;
  localparam int LOGN = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic frame_ready = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;

  logic in_ready, frame_valid, sync_err;
  logic [N*W-1:0] frame_re, frame_im;
  logic in_ready0, frame_valid0, sync_err0;
  logic [N*W-1:0] frame_re0, frame_im0;

  always #5 clk = ~clk;

  fft64_input_framer #(.N(N), .W(W), .BITREV(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_re(frame_re), .frame_im(frame_im), .sync_err(sync_err)
  );

  fft64_input_framer #(.N(N), .W(W), .BITREV(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .frame_valid(frame_valid0), .frame_ready(frame_ready),
    .frame_re(frame_re0), .frame_im(frame_im0), .sync_err(sync_err0)
  );

  int nchecks = 0;
  int nerr = 0;

  // Reference model: samples of the frame in progress by index, plus a queue of finished frames.
  logic [W-1:0]   cur_re [N];
  logic [W-1:0]   cur_im [N];
  int             cnt = 0;
  logic           err_m = 1'b0;
  logic [N*W-1:0] q_re1[$];
  logic [N*W-1:0] q_im1[$];
  logic [N*W-1:0] q_re0[$];
  logic [N*W-1:0] q_im0[$];

  function automatic int bitrev(input int k);
    int r = 0;
    for (int b = 0; b < LOGN; b++) r = (r << 1) | ((k >> b) & 1);
    return r;
  endfunction

  function automatic logic [N*W-1:0] pack(input int rev, input logic im);
    logic [N*W-1:0] f;
    int k;
    f = '0;
    for (int s = 0; s < N; s++) begin
      k = (rev != 0) ? bitrev(s) : s;
      f[s*W +: W] = im ? cur_im[k] : cur_re[k];
    end
    return f;
  endfunction

  function automatic logic [N*W-1:0] head(input int which);
    if (q_re1.size() == 0) return '0;
    case (which)
      0: return q_re1[0];
      1: return q_im1[0];
      2: return q_re0[0];
      default: return q_im0[0];
    endcase
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(3));
  endfunction

  task automatic model_clear();
    q_re1.delete(); q_im1.delete(); q_re0.delete(); q_im0.delete();
    cnt = 0;
    err_m = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic sof, input logic [W-1:0] re,
                       input logic [W-1:0] im, input logic fr);
    logic acc, rel;
    in_valid = v; in_sof = sof; in_re = re; in_im = im; frame_ready = fr;
    acc = v && (q_re1.size() < 2);
    rel = fr && (q_re1.size() > 0);
    @(posedge clk);
    if (rel) begin
      void'(q_re1.pop_front()); void'(q_im1.pop_front());
      void'(q_re0.pop_front()); void'(q_im0.pop_front());
    end
    if (acc) begin
      if (sof && cnt != 0) begin
        cnt = 0;
        err_m = 1'b1;
      end
      cur_re[cnt] = re;
      cur_im[cnt] = im;
      cnt++;
      if (cnt == N) begin
        q_re1.push_back(pack(1, 1'b0)); q_im1.push_back(pack(1, 1'b1));
        q_re0.push_back(pack(0, 1'b0)); q_im0.push_back(pack(0, 1'b1));
        cnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0; frame_ready = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    nchecks++;
    if (frame_valid !== 1'b0 || frame_valid0 !== 1'b0) begin
      nerr++; $display("FAIL reset_frame_valid got %b/%b want 0", frame_valid, frame_valid0);
    end
    nchecks++;
    if (sync_err !== 1'b0) begin nerr++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
    nchecks++;
    if (frame_re !== '0 || frame_im !== '0) begin
      nerr++; $display("FAIL reset_frame got %h/%h want 0", frame_re, frame_im);
    end
  endtask

  task automatic test_bitrev_frame();
    do_reset();
    for (int k = 0; k < N; k++) begin
      cycle(1'b1, k == 0, W'(k), W'(~k), 1'b1);
      nchecks++;
      if (frame_valid !== (q_re1.size() > 0)) begin
        nerr++; $display("FAIL bitrev_valid k=%0d got %b want %b", k, frame_valid, q_re1.size() > 0);
      end
    end
    nchecks++;
    if (frame_re !== head(0) || frame_im !== head(1)) begin
      nerr++; $display("FAIL bitrev_frame got %h/%h want %h/%h", frame_re, frame_im, head(0), head(1));
    end
    nchecks++;
    if (frame_re0 !== head(2) || frame_im0 !== head(3)) begin
      nerr++; $display("FAIL linear_frame got %h/%h want %h/%h", frame_re0, frame_im0, head(2), head(3));
    end
    nchecks++;
    if (frame_re[1*W +: W] !== 2'b00) begin
      nerr++; $display("FAIL bitrev_slot1_re got %b want 00", frame_re[1*W +: W]);
    end
    nchecks++;
    if (frame_re[32*W +: W] !== 2'b01 || frame_im[32*W +: W] !== 2'b10) begin
      nerr++; $display("FAIL bitrev_slot32 got %b/%b want 01/10", frame_re[32*W +: W], frame_im[32*W +: W]);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    nchecks++;
    if (frame_valid !== 1'b0) begin nerr++; $display("FAIL bitrev_pulse got %b want 0", frame_valid); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 2*N; i++) begin
      cycle(1'b1, 1'b0, rnd(), rnd(), 1'b0);
      nchecks++;
      if (in_ready !== (q_re1.size() < 2) || frame_valid !== (q_re1.size() > 0)) begin
        nerr++; $display("FAIL hold_handshake i=%0d got rdy=%b vld=%b want rdy=%b vld=%b",
                         i, in_ready, frame_valid, q_re1.size() < 2, q_re1.size() > 0);
      end
    end
    nchecks++;
    if (in_ready !== 1'b0 || in_ready0 !== 1'b0) begin
      nerr++; $display("FAIL hold_ready_low got %b/%b want 0", in_ready, in_ready0);
    end
    nchecks++;
    if (frame_re !== head(0) || frame_re0 !== head(2) || frame_im0 !== head(3)) begin
      nerr++; $display("FAIL hold_frame0 got %h want %h", frame_re0, head(2));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    nchecks++;
    if (frame_valid !== 1'b1 || frame_re0 !== head(2) || frame_im !== head(1)) begin
      nerr++; $display("FAIL hold_frame1 vld=%b got %h want %h", frame_valid, frame_re0, head(2));
    end
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL hold_ready_back got %b want 1", in_ready); end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    nchecks++;
    if (frame_valid !== 1'b0) begin nerr++; $display("FAIL hold_drain got %b want 0", frame_valid); end
  endtask

  task automatic test_resync();
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, i == 0, rnd(), rnd(), 1'b1);
    cycle(1'b1, 1'b1, 2'b11, rnd(), 1'b1);
    nchecks++;
    if (sync_err !== 1'b1 || sync_err0 !== 1'b1) begin
      nerr++; $display("FAIL resync_err got %b/%b want 1", sync_err, sync_err0);
    end
    for (int i = 0; i < N-1; i++) begin
      cycle(1'b1, 1'b0, rnd(), rnd(), 1'b1);
      nchecks++;
      if (frame_valid !== (q_re1.size() > 0)) begin
        nerr++; $display("FAIL resync_valid i=%0d got %b want %b", i, frame_valid, q_re1.size() > 0);
      end
    end
    nchecks++;
    if (frame_re[0 +: W] !== 2'b11 || frame_re0[0 +: W] !== 2'b11) begin
      nerr++; $display("FAIL resync_slot0 got %b/%b want 11", frame_re[0 +: W], frame_re0[0 +: W]);
    end
    nchecks++;
    if (frame_re !== head(0) || frame_im !== head(1) || frame_re0 !== head(2)) begin
      nerr++; $display("FAIL resync_frame got %h want %h", frame_re, head(0));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    nchecks++;
    if (sync_err !== err_m) begin nerr++; $display("FAIL resync_sticky got %b want %b", sync_err, err_m); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 4*N; i++) begin
      cycle(1'b1, (i % N) == 0, rnd(), rnd(), 1'b1);
      if (frame_valid === 1'b1) pulses++;
      nchecks++;
      if (in_ready !== 1'b1 || frame_valid !== (q_re1.size() > 0)) begin
        nerr++; $display("FAIL b2b_handshake i=%0d got rdy=%b vld=%b want rdy=1 vld=%b",
                         i, in_ready, frame_valid, q_re1.size() > 0);
      end
      if (q_re1.size() > 0) begin
        nchecks++;
        if (frame_re !== head(0) || frame_im !== head(1) || frame_re0 !== head(2) || frame_im0 !== head(3)) begin
          nerr++; $display("FAIL b2b_frame i=%0d got %h want %h", i, frame_re, head(0));
        end
      end
    end
    nchecks++;
    if (pulses !== 4) begin nerr++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < N + 40; i++) cycle(1'b1, 1'b0, rnd(), rnd(), 1'b0);
    nchecks++;
    if (frame_valid !== 1'b1) begin nerr++; $display("FAIL midrst_pre got %b want 1", frame_valid); end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    nchecks++;
    if (frame_valid !== 1'b0 || frame_valid0 !== 1'b0 || frame_re !== '0 || frame_im !== '0) begin
      nerr++; $display("FAIL midrst_outputs vld=%b re=%h im=%h want 0", frame_valid, frame_re, frame_im);
    end
    nchecks++;
    if (in_ready !== 1'b1 || sync_err !== 1'b0) begin
      nerr++; $display("FAIL midrst_ctrl got rdy=%b err=%b want 1/0", in_ready, sync_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, 1'b0, rnd(), rnd(), 1'b0);
      nchecks++;
      if (frame_valid !== (q_re1.size() > 0)) begin
        nerr++; $display("FAIL midrst_valid i=%0d got %b want %b", i, frame_valid, q_re1.size() > 0);
      end
    end
    nchecks++;
    if (frame_re !== head(0) || frame_im !== head(1) || frame_re0 !== head(2)) begin
      nerr++; $display("FAIL midrst_frame got %h want %h", frame_re, head(0));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_full_ignore();
    do_reset();
    for (int i = 0; i < 2*N; i++) cycle(1'b1, 1'b0, rnd(), rnd(), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'($urandom_range(1)), rnd(), rnd(), 1'b0);
      nchecks++;
      if (frame_re !== head(0) || frame_im0 !== head(3) || in_ready !== 1'b0 || sync_err !== 1'b0) begin
        nerr++; $display("FAIL full_ignore i=%0d got re=%h rdy=%b err=%b want re=%h rdy=0 err=0",
                         i, frame_re, in_ready, sync_err, head(0));
      end
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    nchecks++;
    if (frame_re !== head(0) || frame_im !== head(1) || frame_re0 !== head(2)) begin
      nerr++; $display("FAIL full_second got %h want %h", frame_re, head(0));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, 1'b0, rnd(), rnd(), 1'b0);
      nchecks++;
      if (frame_valid !== (q_re1.size() > 0)) begin
        nerr++; $display("FAIL full_refill_valid i=%0d got %b want %b", i, frame_valid, q_re1.size() > 0);
      end
    end
    nchecks++;
    if (frame_re !== head(0) || frame_im !== head(1) || sync_err !== 1'b0) begin
      nerr++; $display("FAIL full_refill_frame got %h want %h err=%b", frame_re, head(0), sync_err);
    end
  endtask

  initial begin
    test_reset();
    test_bitrev_frame();
    test_hold();
    test_resync();
    test_back_to_back();
    test_reset_midframe();
    test_full_ignore();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
